// File: rtl/mix_columns_engine.sv
// mix_columns_engine: handshaked AES MixColumns / InvMixColumns engine.
// A full 128-bit state is latched at acceptance, COLS_PER_CYCLE columns are
// transformed per clock in place, and the result is held until taken.
// Optional build macro: MIXCOL_ROUNDKEY_XOR_EN fuses AddRoundKey (round_key,
// skip_mix ports) into the per-column write-back.

// One 32-bit column through the forward or inverse circulant matrix.
module mix_column (
  input  logic [31:0] col,
  input  logic        inverse,
  output logic [31:0] result
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte split and repeated doubling, shared by both matrices.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
  end

  // Row r uses coefficients rotated by r: fwd {02 03 01 01}, inv {0e 0b 0d 09}.
  always_comb begin
    result = '0;
    for (int r = 0; r < 4; r++) begin
      if (inverse) begin
        result[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                            ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                            ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                            ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      end else begin
        result[31-8*r -: 8] = x2[r]
                            ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                            ^ a[(r+2)%4]
                            ^ a[(r+3)%4];
      end
    end
  end

endmodule

// state | meaning
// IDLE  | ready for a new state, in_ready=1
// BUSY  | transforming COLS_PER_CYCLE columns per clock
// DONE  | result presented, held until out_ready
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
`ifdef MIXCOL_ROUNDKEY_XOR_EN
  ,
  input  logic [127:0] round_key,
  input  logic         skip_mix
`endif
);

  localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [127:0] work;
  logic [1:0]   step_cnt;
  logic         mode;
  logic         last_step;
  int           col_base;

  logic [31:0]  col_in  [COLS_PER_CYCLE];
  logic [31:0]  col_mix [COLS_PER_CYCLE];
  logic [31:0]  col_new [COLS_PER_CYCLE];

`ifdef MIXCOL_ROUNDKEY_XOR_EN
  logic [127:0] key;
  logic         skip;
`endif

  assign last_step = (step_cnt == 2'(NUM_STEPS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; in_ready depends on state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_state = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_state = work;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pick the columns handled this step out of the working register.
  always_comb begin
    col_base = int'(step_cnt) * COLS_PER_CYCLE;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_in[j] = work[127-32*(col_base+j) -: 32];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    mix_column u_mix (
      .col     (col_in[g]),
      .inverse (mode),
      .result  (col_mix[g])
    );
  end

  // Column write-back value, with the round key folded in when built.
  always_comb begin
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
`ifdef MIXCOL_ROUNDKEY_XOR_EN
      col_new[j] = (skip ? col_in[j] : col_mix[j]) ^ key[127-32*(col_base+j) -: 32];
`else
      col_new[j] = col_mix[j];
`endif
    end
  end

  // Datapath: latch at acceptance, then replace columns in place while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      step_cnt <= '0;
      mode     <= 1'b0;
`ifdef MIXCOL_ROUNDKEY_XOR_EN
      key      <= '0;
      skip     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_state;
            mode     <= in_inverse;
            step_cnt <= '0;
`ifdef MIXCOL_ROUNDKEY_XOR_EN
            key      <= round_key;
            skip     <= skip_mix;
`endif
          end
        end
        BUSY: begin
          for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            work[127-32*(col_base+j) -: 32] <= col_new[j];
          end
          step_cnt <= step_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
Parametrised, handshaked MixColumns / InvMixColumns engine for the AES-256 datapath. It accepts a full 128-bit state and processes COLS_PER_CYCLE columns per clock. A per-transaction mode bit selects the forward or inverse matrix, so the encryption and decryption round datapaths share one block. It replaces the per-column combinational inverse helper in the decryption round loop and adds sequencing, backpressure and a forward mode.

Parameters:
COLS_PER_CYCLE, 1, columns computed per clock; legal values 1, 2, 4; any other value is an elaboration error.
NUM_STEPS, 4/COLS_PER_CYCLE, derived (localparam), processing cycles per block.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input state valid
in_ready  output  1  engine can accept a state
in_state  input  128  state; column c = bits [127-32c -: 32]; row 0 byte is the column MSB
in_inverse  input  1  0 = MixColumns [02 03 01 01], 1 = InvMixColumns [0e 0b 0d 09] (circulant rows)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_state  output  128  transformed state, same column/byte layout

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_state=0, step counter=0, mode register=0.
- FSM:
  - IDLE: in_ready=1. On in_valid & in_ready, latch in_state and in_inverse, clear counter, go to BUSY.
  - BUSY: in_ready=0. Each cycle, columns [counter*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1] are replaced in the working register. The counter increments. When counter==NUM_STEPS-1, go to DONE.
  - DONE: out_valid=1, out_state = working register. Hold it stable while out_ready=0. On out_ready, go to IDLE.
- Latency:
  - Acceptance edge at cycle T; out_valid rises after edge T+NUM_STEPS, i.e. 4 / 2 / 1 cycles after acceptance.
  - With out_ready tied high, throughput is one block per NUM_STEPS+2 cycles.
- in_ready is combinational from the state register only. It never depends on in_valid.
- in_valid or input changes during BUSY or DONE are ignored. Inputs are sampled only at the acceptance edge.
- Arithmetic in GF(2^8), polynomial 0x11B.
  - Use xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 0).
  - x9 = x8^x1, xb = x8^x2^x1, xd = x8^x4^x1, xe = x8^x4^x2.
  - No lookup tables. The per-column multiplier is purely combinational, instantiated COLS_PER_CYCLE times.
- Mode is latched per transaction. Back-to-back blocks may alternate mode.
- rst asserted mid-BUSY or mid-DONE: next edge returns to the reset values. The partial result is discarded and no out_valid is produced.
- out_valid & out_ready in DONE: in_ready stays 0 that cycle; the next block is accepted no earlier than the following cycle.

Optional Feature:
- Macro MIXCOL_ROUNDKEY_XOR_EN.
- When defined, adds these ports:
  - round_key input 128, latched with in_state at acceptance.
  - skip_mix input 1, latched at acceptance.
- With the macro, out_state = MixColumns/InvMixColumns(state) ^ round_key, which fuses AddRoundKey.
  - If skip_mix=1 (final round), out_state = state ^ round_key.
  - Latency is unchanged; the XOR is applied per column as it is computed.
- Without the macro:
  - the ports do not exist;
  - no key register is built;
  - behaviour is exactly as above.

Test Plan:
- Forward, COLS_PER_CYCLE=1, in_state=d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> out_state=046681e5_e0cb199a_48f8d37a_2806264c. out_valid rises 4 cycles after acceptance.
- Inverse, same params, in_state=046681e5_e0cb199a_48f8d37a_2806264c -> d4bf5d30_e0b452ae_b84111f1_1e2798e5.
- Forward, COLS_PER_CYCLE=4, in_state=db135345_f20a225c_01010101_c6c6c6c6 -> 8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1 cycle latency. Repeat with COLS_PER_CYCLE=2 and check 2 cycle latency.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable, in_ready=0. Drive a new in_state/in_valid in that window -> it is not accepted and does not affect the result.
- Back-to-back alternating modes, with out_ready=1 and in_valid=1 continuously, 8 blocks -> each result is correct for its latched mode. Acceptances are exactly NUM_STEPS+2 cycles apart.
- rst pulsed on the 2nd BUSY cycle (COLS_PER_CYCLE=1) -> the next cycle shows in_ready=1, out_valid=0, out_state=0, and no result is emitted. Under MIXCOL_ROUNDKEY_XOR_EN, skip_mix=1 with key=all-ones on state 0 -> ffff…ff.
